// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, requester ids and CDB slot layout for the CDB arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    localparam int NUM_REQ = 6;
    localparam int NUM_CDB = 2;
    localparam int PR_W    = 7;
    localparam int AR_W    = 5;
    localparam int SRC_W   = 3;

    // Multipliers cannot stall internally, so they are served ahead of round-robin
    // when the priority build option is enabled.
    localparam logic [NUM_REQ-1:0] PRIO_MASK = 6'b001100;

    localparam int REQ_SIM0 = 0;
    localparam int REQ_SIM1 = 1;
    localparam int REQ_MUL0 = 2;
    localparam int REQ_MUL1 = 3;
    localparam int REQ_MEM0 = 4;
    localparam int REQ_MEM1 = 5;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  pr_tag;
        logic [AR_W-1:0]  ar_tag;
        logic             exception;
        logic [SRC_W-1:0] src;
    } cdb_slot_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Circular scan from start_ptr selecting up to slots_avail requesters, one-hot per slot.
// Latency: purely combinational.
// Backpressure: requesters beyond slots_avail are simply not picked this cycle.
module cdb_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = NUM_REQ,
    parameter int N_CDB = NUM_CDB,
    parameter int CNT_W = $clog2(N_CDB + 1)
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [SRC_W-1:0]            start_ptr,
    input  logic [CNT_W-1:0]            slots_avail,
    output logic [N_CDB-1:0][N_REQ-1:0] picks,
    output logic [SRC_W-1:0]            next_ptr
);

    // Walk requesters in circular order; the j-th hit fills pick j, pointer moves past the last hit.
    always_comb begin
        int idx;
        int cnt;
        picks    = '0;
        next_ptr = start_ptr;
        cnt      = 0;
        idx      = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(start_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx] && (cnt < int'(slots_avail)) && (cnt < N_CDB)) begin
                picks[cnt][idx] = 1'b1;
                cnt             = cnt + 1;
                // Wrap is modulo N_REQ, which need not be a power of two.
                next_ptr        = (idx == N_REQ - 1) ? '0 : SRC_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares N_CDB common-data-bus slots among completing FUs (optional priority pre-pick: CDB_ARB_PRIO_EN).
// Latency: req_grant same cycle (combinational); broadcast on cdb_* one cycle after grant, lasting one cycle.
// Backpressure: ungranted requesters hold req_valid and payload until granted; flush grants nothing.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = NUM_REQ,
    parameter int N_CDB = NUM_CDB
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PR_W-1:0]  req_pr_idx,
    input  logic [N_REQ*AR_W-1:0]  req_ar_idx,
    input  logic [N_REQ-1:0]       req_exception,
    output logic [N_REQ-1:0]       req_grant,
    output logic [N_CDB-1:0]       cdb_valid,
    output logic [N_CDB*PR_W-1:0]  cdb_pr_tag,
    output logic [N_CDB*AR_W-1:0]  cdb_ar_tag,
    output logic [N_CDB-1:0]       cdb_exception,
    output logic [N_CDB*SRC_W-1:0] cdb_src
);

    localparam int CNT_W = $clog2(N_CDB + 1);

    logic [SRC_W-1:0]            rr_ptr;
    logic [SRC_W-1:0]            rr_next;
    logic [N_REQ-1:0]            rr_req;
    logic [CNT_W-1:0]            rr_avail;
    logic [N_CDB-1:0][N_REQ-1:0] rr_pick;
    logic [N_CDB-1:0][N_REQ-1:0] prio_sel;
    logic [CNT_W-1:0]            prio_cnt;
    logic [N_CDB-1:0][N_REQ-1:0] slot_sel;
    cdb_slot_t [N_CDB-1:0]       slot_nxt;
    cdb_slot_t [N_CDB-1:0]       cdb_q;

`ifdef CDB_ARB_PRIO_EN
    // Priority requesters take the lowest slots in ascending index order; the rest go round-robin.
    always_comb begin
        prio_sel = '0;
        prio_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && PRIO_MASK[i] && (int'(prio_cnt) < N_CDB)) begin
                prio_sel[prio_cnt][i] = 1'b1;
                prio_cnt              = prio_cnt + CNT_W'(1);
            end
        end
        rr_req   = req_valid & ~N_REQ'(PRIO_MASK);
        rr_avail = CNT_W'(N_CDB) - prio_cnt;
    end
`else
    // Pure round-robin over every requester.
    always_comb begin
        prio_sel = '0;
        prio_cnt = '0;
        rr_req   = req_valid;
        rr_avail = CNT_W'(N_CDB);
    end
`endif

    cdb_rr_picker #(
        .N_REQ (N_REQ),
        .N_CDB (N_CDB),
        .CNT_W (CNT_W)
    ) u_picker (
        .req         (rr_req),
        .start_ptr   (rr_ptr),
        .slots_avail (rr_avail),
        .picks       (rr_pick),
        .next_ptr    (rr_next)
    );

    // Slot k holds a priority pick if one exists, otherwise the next round-robin pick.
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < N_CDB; k++) begin
            if (k < int'(prio_cnt)) begin
                slot_sel[k] = prio_sel[k];
            end else begin
                slot_sel[k] = rr_pick[k - int'(prio_cnt)];
            end
        end
    end

    // Grants are the union of all slot selections, suppressed during flush and reset.
    always_comb begin
        req_grant = '0;
        for (int k = 0; k < N_CDB; k++) begin
            req_grant = req_grant | slot_sel[k];
        end
        if (flush || !reset) begin
            req_grant = '0;
        end
    end

    // Steer each selected requester's payload into its slot; empty slots stay all-zero.
    always_comb begin
        slot_nxt = '0;
        for (int k = 0; k < N_CDB; k++) begin
            slot_nxt[k].valid = |slot_sel[k];
            for (int i = 0; i < N_REQ; i++) begin
                if (slot_sel[k][i]) begin
                    slot_nxt[k].pr_tag    = req_pr_idx[i*PR_W +: PR_W];
                    slot_nxt[k].ar_tag    = req_ar_idx[i*AR_W +: AR_W];
                    slot_nxt[k].exception = req_exception[i];
                    slot_nxt[k].src       = SRC_W'(i);
                end
            end
        end
    end

    // Pointer and broadcast registers; flush clears the bus and freezes the pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else if (flush) begin
            cdb_q  <= '0;
        end else begin
            rr_ptr <= rr_next;
            cdb_q  <= slot_nxt;
        end
    end

    // Flatten the registered slots onto the packed output buses.
    always_comb begin
        cdb_valid     = '0;
        cdb_pr_tag    = '0;
        cdb_ar_tag    = '0;
        cdb_exception = '0;
        cdb_src       = '0;
        for (int k = 0; k < N_CDB; k++) begin
            cdb_valid[k]                = cdb_q[k].valid;
            cdb_pr_tag[k*PR_W +: PR_W]  = cdb_q[k].pr_tag;
            cdb_ar_tag[k*AR_W +: AR_W]  = cdb_q[k].ar_tag;
            cdb_exception[k]            = cdb_q[k].exception;
            cdb_src[k*SRC_W +: SRC_W]   = cdb_q[k].src;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants, round-robin order, wrap, flush and reset.
// Latency: checks grants 1-2 time units after inputs change and cdb_* 1 unit after the edge.
// Backpressure: models requesters that hold until granted.
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [5:0]  req_valid;
    logic [41:0] req_pr_idx;
    logic [29:0] req_ar_idx;
    logic [5:0]  req_exception;
    logic [5:0]  req_grant;
    logic [1:0]  cdb_valid;
    logic [13:0] cdb_pr_tag;
    logic [9:0]  cdb_ar_tag;
    logic [1:0]  cdb_exception;
    logic [5:0]  cdb_src;

    int checks;
    int errors;

    cdb_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_pr_idx    (req_pr_idx),
        .req_ar_idx    (req_ar_idx),
        .req_exception (req_exception),
        .req_grant     (req_grant),
        .cdb_valid     (cdb_valid),
        .cdb_pr_tag    (cdb_pr_tag),
        .cdb_ar_tag    (cdb_ar_tag),
        .cdb_exception (cdb_exception),
        .cdb_src       (cdb_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Requester i: pr tag 40+i, ar tag i+1, only requester 4 flags an exception.
    task automatic load_payload();
        for (int i = 0; i < 6; i++) begin
            req_pr_idx[i*7 +: 7] = 7'(40 + i);
            req_ar_idx[i*5 +: 5] = 5'(i + 1);
        end
        req_exception = 6'b010000;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        load_payload();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        load_payload();
        #1;
        reset     = 1'b0;
        req_valid = 6'b111111;
        #3;
        checks++;
        if (req_grant !== 6'b000000) begin
            errors++;
            $display("FAIL reset_grant: got %b expected %b", req_grant, 6'b000000);
        end
        checks++;
        if (cdb_valid !== 2'b00 || cdb_pr_tag !== 14'd0 || cdb_ar_tag !== 10'd0) begin
            errors++;
            $display("FAIL reset_bus: got valid=%b pr=%h ar=%h expected all zero", cdb_valid, cdb_pr_tag, cdb_ar_tag);
        end
        checks++;
        if (cdb_exception !== 2'b00 || cdb_src !== 6'd0) begin
            errors++;
            $display("FAIL reset_src_exc: got exc=%b src=%h expected zero", cdb_exception, cdb_src);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_pr_idx[6:0] = 7'd33;
        req_ar_idx[4:0] = 5'd4;
        req_valid       = 6'b000001;
        #1;
        checks++;
        if (req_grant !== 6'b000001) begin
            errors++;
            $display("FAIL single_grant: got %b expected %b", req_grant, 6'b000001);
        end
        tick();
        req_valid = '0;
        checks++;
        if (cdb_valid !== 2'b01 || cdb_pr_tag !== {7'd0, 7'd33} || cdb_ar_tag !== {5'd0, 5'd4}) begin
            errors++;
            $display("FAIL single_bcast: got valid=%b pr=%h ar=%h expected 01/%h/%h",
                     cdb_valid, cdb_pr_tag, cdb_ar_tag, {7'd0, 7'd33}, {5'd0, 5'd4});
        end
        checks++;
        if (cdb_src !== 6'd0 || cdb_exception !== 2'b00) begin
            errors++;
            $display("FAIL single_src: got src=%h exc=%b expected 0/00", cdb_src, cdb_exception);
        end
        tick();
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_one_cycle: got %b expected %b", cdb_valid, 2'b00);
        end
        load_payload();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 6'b111111;
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL rr_grant0: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        req_valid = 6'b111100;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_src !== {3'd1, 3'd0}) begin
            errors++;
            $display("FAIL rr_bcast0: got valid=%b src=%h expected 11/%h", cdb_valid, cdb_src, {3'd1, 3'd0});
        end
        #1;
        checks++;
        if (req_grant !== 6'b001100) begin
            errors++;
            $display("FAIL rr_grant1: got %b expected %b", req_grant, 6'b001100);
        end
        tick();
        req_valid = 6'b110000;
        checks++;
        if (cdb_src !== {3'd3, 3'd2} || cdb_pr_tag !== {7'd43, 7'd42}) begin
            errors++;
            $display("FAIL rr_bcast1: got src=%h pr=%h expected %h/%h", cdb_src, cdb_pr_tag, {3'd3, 3'd2}, {7'd43, 7'd42});
        end
        #1;
        checks++;
        if (req_grant !== 6'b110000) begin
            errors++;
            $display("FAIL rr_grant2: got %b expected %b", req_grant, 6'b110000);
        end
        tick();
        req_valid = 6'b111111;
        checks++;
        if (cdb_src !== {3'd5, 3'd4} || cdb_ar_tag !== {5'd6, 5'd5} || cdb_exception !== 2'b01) begin
            errors++;
            $display("FAIL rr_bcast2: got src=%h ar=%h exc=%b expected %h/%h/01",
                     cdb_src, cdb_ar_tag, cdb_exception, {3'd5, 3'd4}, {5'd6, 5'd5});
        end
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL rr_ptr_wrap0: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 6'b010000;
        #1;
        checks++;
        if (req_grant !== 6'b010000) begin
            errors++;
            $display("FAIL wrap_setup: got %b expected %b", req_grant, 6'b010000);
        end
        tick();
        req_valid = 6'b100001;
        #1;
        checks++;
        if (req_grant !== 6'b100001) begin
            errors++;
            $display("FAIL wrap_grant: got %b expected %b", req_grant, 6'b100001);
        end
        tick();
        req_valid = 6'b000011;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_src !== {3'd0, 3'd5}) begin
            errors++;
            $display("FAIL wrap_bcast: got valid=%b src=%h expected 11/%h", cdb_valid, cdb_src, {3'd0, 3'd5});
        end
        tick();
        req_valid = '0;
        checks++;
        if (cdb_src !== {3'd0, 3'd1}) begin
            errors++;
            $display("FAIL wrap_ptr1: got src=%h expected %h", cdb_src, {3'd0, 3'd1});
        end
    endtask

    task automatic test_starvation();
        do_reset();
        req_valid = 6'b001111;
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL starve_c0: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        // 0 and 1 present fresh results; 2 and 3 still waiting.
        req_valid = 6'b001111;
        #1;
        checks++;
        if (req_grant !== 6'b001100) begin
            errors++;
            $display("FAIL starve_c1: got %b expected %b", req_grant, 6'b001100);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        req_valid = 6'b000011;
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL flush_pre: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        req_valid = 6'b111100;
        flush     = 1'b1;
        #1;
        checks++;
        if (req_grant !== 6'b000000 || cdb_valid !== 2'b11) begin
            errors++;
            $display("FAIL flush_grant: got grant=%b valid=%b expected 000000/11", req_grant, cdb_valid);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (cdb_valid !== 2'b00 || cdb_src !== 6'd0 || cdb_pr_tag !== 14'd0) begin
            errors++;
            $display("FAIL flush_clear: got valid=%b src=%h pr=%h expected zero", cdb_valid, cdb_src, cdb_pr_tag);
        end
        #1;
        checks++;
        if (req_grant !== 6'b001100) begin
            errors++;
            $display("FAIL flush_ptr_hold: got %b expected %b", req_grant, 6'b001100);
        end
        tick();
        req_valid = 6'b111111;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_src !== {3'd3, 3'd2}) begin
            errors++;
            $display("FAIL flush_after: got valid=%b src=%h expected 11/%h", cdb_valid, cdb_src, {3'd3, 3'd2});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 2'b00 || cdb_pr_tag !== 14'd0 || cdb_src !== 6'd0 || req_grant !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b pr=%h src=%h grant=%b expected zero",
                     cdb_valid, cdb_pr_tag, cdb_src, req_grant);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL reset_ptr0: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        req_valid = '0;
    endtask

`ifdef CDB_ARB_PRIO_EN
    task automatic test_prio();
        do_reset();
        req_valid = 6'b111111;
        #1;
        checks++;
        if (req_grant !== 6'b001100) begin
            errors++;
            $display("FAIL prio_grant0: got %b expected %b", req_grant, 6'b001100);
        end
        tick();
        req_valid = 6'b110011;
        checks++;
        if (cdb_src !== {3'd3, 3'd2}) begin
            errors++;
            $display("FAIL prio_bcast0: got %h expected %h", cdb_src, {3'd3, 3'd2});
        end
        #1;
        checks++;
        if (req_grant !== 6'b000011) begin
            errors++;
            $display("FAIL prio_grant1: got %b expected %b", req_grant, 6'b000011);
        end
        tick();
        req_valid = '0;
        checks++;
        if (cdb_src !== {3'd1, 3'd0}) begin
            errors++;
            $display("FAIL prio_bcast1: got %h expected %h", cdb_src, {3'd1, 3'd0});
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_wrap();
        test_flush_and_reset();
`ifdef CDB_ARB_PRIO_EN
        test_prio();
`else
        test_round_robin();
        test_starvation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completing functional units (two simple ALUs, two multipliers, two memory ports) onto a limited number of common-data-bus broadcast slots. Sits between the execute stage and the CDB consumers (RS, ROB, map table), replacing the direct one-lane-per-FU connection with round-robin sharing and a valid/grant handshake that back-pressures the functional units. Broadcast outputs are registered.

## Interface
- N_REQ, 6, number of requesters; index 0/1 sim ALU, 2/3 mul, 4/5 mem
- N_CDB, 2, number of broadcast slots per cycle (1..N_REQ)
- PR_W, 7, physical register tag width
- AR_W, 5, architectural register tag width
- SRC_W, 3, requester-id width, ≥ clog2(N_REQ)
- PRIO_MASK, 6'b001100, requesters served before round-robin; used only with CDB_ARB_PRIO_EN
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; asserted at 0
- flush  in  1  squash: drop this cycle's arbitration, clear bus
- req_valid  in  N_REQ  requester i has a completed result
- req_pr_idx  in  N_REQ*PR_W  destination physical tag, requester i at [i*PR_W +: PR_W]
- req_ar_idx  in  N_REQ*AR_W  destination architectural tag, packed likewise
- req_exception  in  N_REQ  result raised an exception
- req_grant  out  N_REQ  combinational; requester i's result is accepted this cycle
- cdb_valid  out  N_CDB  slot k broadcasting
- cdb_pr_tag  out  N_CDB*PR_W  slot k physical tag
- cdb_ar_tag  out  N_CDB*AR_W  slot k architectural tag
- cdb_exception  out  N_CDB  slot k exception flag
- cdb_src  out  N_CDB*SRC_W  slot k requester index

## Operation
- State: rr_ptr (SRC_W bits, range 0..N_REQ-1) plus the registered cdb_* outputs.
- Each cycle, scan requesters circularly from rr_ptr; the first N_CDB with req_valid=1 are granted. The j-th granted requester in scan order fills slot j; remaining slots have valid 0.
- rr_ptr next = (index of last granted requester + 1) mod N_REQ; unchanged if nothing granted. Wrap is modulo N_REQ, not a power of two.
- Handshake: requester holds req_valid and payload stable until it sees req_grant=1 at a rising edge. It deasserts the cycle after grant or presents a new result. Dropping req_valid without a grant is legal only while flush=1.
- flush=1: req_grant all 0, rr_ptr holds, all cdb_* cleared at next edge.
- Unused slots: cdb_valid 0, tag/exception/src fields driven 0.
- Fewer than N_CDB requests: all granted, no stall.

## Timing
- Reset (reset=0, asynchronous): rr_ptr=0, cdb_valid=0, cdb_pr_tag=0, cdb_ar_tag=0, cdb_exception=0, cdb_src=0. req_grant is 0 while reset is asserted.
- Grant is combinational, same cycle as request. The broadcast for that grant appears on cdb_* exactly one cycle later and lasts one cycle.
- Reset deasserted mid-request: arbitration starts from rr_ptr=0 on the first edge after release. Nothing granted before reset is replayed.
- Simultaneous flush and requests: flush wins.

## Configuration
- CDB_ARB_PRIO_EN defined: requesters whose PRIO_MASK bit is set are granted first, in ascending index order. Remaining slots go round-robin among the others. rr_ptr advances only on non-priority grants. Default mask favours the multipliers, which cannot stall internally.
- Undefined: PRIO_MASK ignored; pure round-robin over all requesters.

## Structure
- Shared package: PR_W, AR_W, requester index constants (REQ_SIM0..REQ_MEM1), and the cdb slot struct typedef {valid, pr_tag, ar_tag, exception, src}.
- One sub-module: cdb_rr_picker. It is combinational, taking a request vector and a start pointer, and returns up to N_CDB one-hot picks plus the next pointer. The top holds rr_ptr, the priority pre-pick, and the output registers.

## Test plan
- Reset then req_valid=6'b000001, pr_idx0=7'd33, ar_idx0=5'd4 -> req_grant=6'b000001 same cycle; next cycle cdb_valid=2'b01, slot0 pr=33, ar=4, src=0.
- All six valid, rr_ptr=0, held for 3 cycles -> grants {0,1}, {2,3}, {4,5}; rr_ptr 2, 4, 0; each broadcast one cycle after its grant.
- rr_ptr=5, req_valid=6'b100001 -> slot0=src5, slot1=src0 (wrap), rr_ptr becomes 1.
- Requester 3 held valid while 0,1,2 continuously valid -> 3 granted within 2 cycles; no starvation.
- flush=1 with 4 requests valid -> req_grant=0, next cycle cdb_valid=0, rr_ptr unchanged. Reset pulled low mid-broadcast -> cdb_* zero immediately, without waiting for a clock edge.
- CDB_ARB_PRIO_EN, all valid, rr_ptr=0 -> grants {2,3} first; rr_ptr stays 0. Next cycle grants {0,1} once 2 and 3 have dropped req_valid.
